// File: rtl/md_unit_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, FSM states
// and default latencies.
package md_unit_pkg;

    // Decoded MD op as delivered by the ID/EX register; 7 is reserved and
    // behaves like MD_NONE.
    typedef enum logic [2:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6,
        MD_RSVD  = 3'd7
    } md_op_e;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } md_state_e;

    localparam int DEF_MULT_LAT = 5;
    localparam int DEF_DIV_LAT  = 10;

    // Latencies are limited to 1..31, so a 5-bit down-counter suffices.
    localparam int CNT_W = 5;

endpackage

// File: rtl/md_unit_compute.sv
// Combinational arithmetic core: signed/unsigned 32x32 multiply and divide.
// The result is captured by md_unit at the issue edge, so this block only
// has to be correct for the operands present in that cycle.
module md_compute
    import md_unit_pkg::*;
(
    input  md_op_e      op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        div_by_zero
);

    logic signed [63:0] prod_s;
    logic        [63:0] prod_u;
    logic               div_ovf;
    logic        [31:0] b_div;
    logic signed [31:0] a_s;
    logic signed [31:0] b_s;
    logic signed [31:0] q_s;
    logic signed [31:0] r_s;
    logic        [31:0] q_u;
    logic        [31:0] r_u;

    assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    assign prod_u = {32'd0, a} * {32'd0, b};

    // The most-negative / -1 quotient does not fit in 32 bits and a zero
    // divisor has no result at all; both are patched below, so the divider
    // is fed a harmless divisor of 1 to keep simulation well-defined.
    assign div_ovf     = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    assign div_by_zero = (b == 32'd0);
    assign b_div       = (div_by_zero || div_ovf) ? 32'd1 : b;

    assign a_s = a;
    assign b_s = b_div;
    assign q_s = a_s / b_s;
    assign r_s = a_s % b_s;
    assign q_u = a / b_div;
    assign r_u = a % b_div;

    // Select the HI/LO pair for the requested op.
    always_comb begin
        hi = 32'd0;
        lo = 32'd0;
        case (op)
            MD_MULT: begin
                hi = prod_s[63:32];
                lo = prod_s[31:0];
            end
            MD_MULTU: begin
                hi = prod_u[63:32];
                lo = prod_u[31:0];
            end
            MD_DIV: begin
                if (div_ovf) begin
                    hi = 32'd0;
                    lo = 32'h8000_0000;
                end else begin
                    hi = r_s;
                    lo = q_s;
                end
            end
            MD_DIVU: begin
                hi = r_u;
                lo = q_u;
            end
            default: begin
                hi = 32'd0;
                lo = 32'd0;
            end
        endcase
    end

endmodule

// File: rtl/md_unit.sv
// EX-stage multiply/divide unit. Owns the architectural HI/LO registers and
// holds busy high for a fixed latency so the hazard unit can stall the
// front end while a MULT/DIV is in flight.
module md_unit
    import md_unit_pkg::*;
#(
    parameter int MULT_LAT = DEF_MULT_LAT,
    parameter int DIV_LAT  = DEF_DIV_LAT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    md_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;
    logic [31:0]      pend_hi_q, pend_hi_d;
    logic [31:0]      pend_lo_q, pend_lo_d;
    logic             pend_dz_q, pend_dz_d;

    md_op_e           op_e;
    logic [31:0]      calc_hi;
    logic [31:0]      calc_lo;
    logic             calc_dz;

    assign op_e = md_op_e'(op);

    md_compute u_compute (
        .op          (op_e),
        .a           (A),
        .b           (B),
        .hi          (calc_hi),
        .lo          (calc_lo),
        .div_by_zero (calc_dz)
    );

    // Control state and architectural HI/LO, cleared asynchronously.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    // Pending result holds data only; an aborted op is discarded because the
    // FSM returns to IDLE and never commits it.
    always_ff @(posedge clk) begin
        pend_hi_q <= pend_hi_d;
        pend_lo_q <= pend_lo_d;
        pend_dz_q <= pend_dz_d;
    end

    // Next-state, counter and HI/LO update logic.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        pend_dz_d = pend_dz_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    case (op_e)
                        MD_MULT, MD_MULTU: begin
                            pend_hi_d = calc_hi;
                            pend_lo_d = calc_lo;
                            pend_dz_d = 1'b0;
                            cnt_d     = CNT_W'(MULT_LAT);
                            state_d   = BUSY;
                        end
                        MD_DIV, MD_DIVU: begin
                            pend_hi_d = calc_hi;
                            pend_lo_d = calc_lo;
                            pend_dz_d = calc_dz;
                            cnt_d     = CNT_W'(DIV_LAT);
                            state_d   = BUSY;
                        end
                        MD_MTHI: hi_d = A;
                        MD_MTLO: lo_d = A;
                        default: ;
                    endcase
                end
            end
            BUSY: begin
                // Any start seen here is ignored; the hazard unit replays it.
                if (cnt_q == CNT_W'(1)) begin
                    if (!pend_dz_q) begin
                        hi_d = pend_hi_q;
                        lo_d = pend_lo_q;
                    end
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign busy = (state_q == BUSY);
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Scoreboard bench for md_unit: stimulus pushes the expected commit
// (latency, HI, LO) for each long op; a monitor pops on every falling busy.
module tb_md_unit;
    import md_unit_pkg::*;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic [31:0] lat;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t exp_q[$];

    md_unit #(.MULT_LAT(5), .DIV_LAT(10)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .HI    (HI),
        .LO    (LO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s actual=%h required=%h", name, act, req);
    endtask

    // Monitor: measures each busy window and checks the committed HI/LO.
    logic        prev_busy = 1'b0;
    logic        in_op     = 1'b0;
    logic [31:0] cyc       = 0;
    logic [31:0] snap_hi   = 0;
    logic [31:0] snap_lo   = 0;
    logic        changed   = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            in_op     = 1'b0;
            prev_busy = 1'b0;
        end else begin
            if (busy && !prev_busy) begin
                in_op   = 1'b1;
                cyc     = 0;
                snap_hi = HI;
                snap_lo = LO;
                changed = 1'b0;
            end
            if (busy) begin
                cyc = cyc + 1;
                if (HI !== snap_hi || LO !== snap_lo) changed = 1'b1;
            end
            if (!busy && prev_busy && in_op) begin
                in_op = 1'b0;
                if (exp_q.size() == 0) begin
                    check("unexpected_commit", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("busy_cycles", cyc, e.lat);
                    check("hilo_stable_while_busy", {31'd0, changed}, 32'd0);
                    check("commit_HI", HI, e.hi);
                    check("commit_LO", LO, e.lo);
                end
            end
            prev_busy = busy;
        end
    end

    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        @(posedge clk);
        #1;
        start = 1'b1;
        op    = o;
        A     = a;
        B     = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        op    = 3'd0;
    endtask

    task automatic expect_commit(input logic [31:0] lat, input logic [31:0] hi, input logic [31:0] lo);
        exp_t e;
        e.lat = lat;
        e.hi  = hi;
        e.lo  = lo;
        exp_q.push_back(e);
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (busy && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (busy) check("busy_timeout", {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        start = 1'b0;
        op    = 3'd0;
        A     = 32'd0;
        B     = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_HI", HI, 32'd0);
        check("reset_LO", LO, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        reset = 1'b1;

        // MULT -3 * 5
        expect_commit(5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
        issue(MD_MULT, 32'hFFFF_FFFD, 32'd5);
        A = 32'h5555_5555;
        B = 32'hAAAA_AAAA;
        wait_idle();

        // MULTU max * max
        expect_commit(5, 32'hFFFF_FFFE, 32'h0000_0001);
        issue(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_idle();

        // DIV -7 / 2
        expect_commit(10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        issue(MD_DIV, 32'hFFFF_FFF9, 32'd2);
        wait_idle();

        // DIV overflow case
        expect_commit(10, 32'h0000_0000, 32'h8000_0000);
        issue(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_idle();

        // Reserved op: no effect
        issue(3'd7, 32'hCAFE_F00D, 32'd3);
        check("rsvd_busy", {31'd0, busy}, 32'd0);
        check("rsvd_HI", HI, 32'h0000_0000);
        check("rsvd_LO", LO, 32'h8000_0000);

        // MTHI, visible one cycle later, no busy
        issue(MD_MTHI, 32'h1234_5678, 32'd0);
        check("mthi_HI", HI, 32'h1234_5678);
        check("mthi_LO_kept", LO, 32'h8000_0000);
        check("mthi_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        check("mthi_busy_later", {31'd0, busy}, 32'd0);

        // DIVU by zero: full latency, HI/LO untouched
        expect_commit(10, 32'h1234_5678, 32'h8000_0000);
        issue(MD_DIVU, 32'd9, 32'd0);
        wait_idle();

        // MTLO sets LO
        issue(MD_MTLO, 32'h0BAD_BEEF, 32'd0);
        check("mtlo_LO", LO, 32'h0BAD_BEEF);
        check("mtlo_HI_kept", HI, 32'h1234_5678);

        // MULT 2*3 with MTLO and DIV attempted while busy
        expect_commit(5, 32'd0, 32'd6);
        issue(MD_MULT, 32'd2, 32'd3);
        @(posedge clk);
        #1;
        start = 1'b1;
        op    = MD_MTLO;
        A     = 32'h0000_DEAD;
        B     = 32'd0;
        @(posedge clk);
        #1;
        op    = MD_DIV;
        A     = 32'd100;
        B     = 32'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        op    = 3'd0;
        wait_idle();

        // Async reset in the middle of a DIV
        issue(MD_DIV, 32'd100, 32'd7);
        repeat (3) @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        check("async_rst_HI", HI, 32'd0);
        check("async_rst_LO", LO, 32'd0);
        check("async_rst_busy", {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Fresh MULTU after reset
        expect_commit(5, 32'd0, 32'd16);
        issue(MD_MULTU, 32'd4, 32'd4);
        wait_idle();

        repeat (3) @(posedge clk);
        check("scoreboard_drained", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
